// File: rtl/bus_frame_checker_if.sv
// Bus between the bus_control stage, the frame checker and the popping consumer.
// The master side drives words and pops; the slave side is the checker.
interface bus_frame_checker_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic [3:0]        control_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              seq_error;
  logic              overflow;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  drop_count;
  logic [1:0]        state;

  modport master (
    output data_in, control_in, pop,
    input  data_out, valid_out, full, seq_error, overflow, err_count, drop_count, state
  );

  modport slave (
    input  data_in, control_in, pop,
    output data_out, valid_out, full, seq_error, overflow, err_count, drop_count, state
  );
endinterface

// File: rtl/bus_frame_checker.sv
// Validates header/sequence of offered words and buffers good words in a small FWFT FIFO.
// Keeps saturating reject/drop statistics and a sticky overflow flag.
module bus_frame_checker #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               reset,
  bus_frame_checker_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    ERROR  = 2'b10
  } state_t;

  state_t            state_q;
  logic [3:0]        expected_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic [OCC_W-1:0]  count_next;
  logic              valid_q;
  logic              full_q;
  logic              seq_error_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [CNT_W-1:0]  drop_count_q;

  logic       offer;
  logic       reject;
  logic       good;
  logic       push_ok;
  logic       drop;
  logic       do_pop;
  logic [3:0] header;
  logic [3:0] seq;
  logic       unused_bits;

  assign header      = bus.data_in[DATA_W-1 -: 4];
  assign seq         = bus.data_in[3:0];
  assign unused_bits = ^{bus.control_in[3:2], bus.data_in[DATA_W-5:4]};

  // A full FIFO drops the word even if a pop happens in the same cycle.
  always_comb begin
    offer   = bus.control_in[0];
    reject  = offer && (bus.control_in[1] || (header != 4'hF) ||
                        ((state_q == ACTIVE) && (seq != expected_q)));
    good    = offer && !reject;
    push_ok = good && !full_q;
    drop    = good && full_q;
    do_pop  = bus.pop && valid_q;
    count_next = count;
    if (push_ok && !do_pop)
      count_next = count + OCC_W'(1);
    else if (!push_ok && do_pop)
      count_next = count - OCC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      valid_q <= (count_next != '0);
      full_q  <= (count_next == OCC_W'(DEPTH));
    end
  end

  // Sequence tracking: a good word outside ACTIVE resynchronises on its own sequence nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      expected_q   <= 4'd0;
      seq_error_q  <= 1'b0;
      overflow_q   <= 1'b0;
      err_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      seq_error_q <= reject;
      if (reject) begin
        state_q <= ERROR;
        if (err_count_q != '1)
          err_count_q <= err_count_q + CNT_W'(1);
      end else if (good) begin
        state_q    <= ACTIVE;
        expected_q <= (state_q == ACTIVE) ? expected_q + 4'd1 : seq + 4'd1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != '1)
          drop_count_q <= drop_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.data_out   = mem[rd_ptr];
  assign bus.valid_out  = valid_q;
  assign bus.full       = full_q;
  assign bus.seq_error  = seq_error_q;
  assign bus.overflow   = overflow_q;
  assign bus.err_count  = err_count_q;
  assign bus.drop_count = drop_count_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_bus_frame_checker.sv
// Directed bench for bus_frame_checker: reset, resync, wrap, overflow, push+pop and upstream errors.
module tb_bus_frame_checker;
  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  bus_frame_checker_if #(.DATA_W(16), .CNT_W(8)) bus ();

  bus_frame_checker #(.DATA_W(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] ctrl, input logic pop);
    @(negedge clk);
    bus.data_in    = data;
    bus.control_in = ctrl;
    bus.pop        = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    bus.data_in    = '0;
    bus.control_in = '0;
    bus.pop        = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.data_in    = '0;
    bus.control_in = '0;
    bus.pop        = 1'b0;
    #12;
    checkOutput("rst_data",  32'(bus.data_out),   32'h0);
    checkOutput("rst_valid", 32'(bus.valid_out),  32'h0);
    checkOutput("rst_full",  32'(bus.full),       32'h0);
    checkOutput("rst_serr",  32'(bus.seq_error),  32'h0);
    checkOutput("rst_ovf",   32'(bus.overflow),   32'h0);
    checkOutput("rst_err",   32'(bus.err_count),  32'h0);
    checkOutput("rst_drop",  32'(bus.drop_count), 32'h0);
    checkOutput("rst_state", 32'(bus.state),      32'h0);
    @(negedge clk);
    reset = 1'b0;

    // T1: reset asserted mid-stream with three words buffered
    applyStimulus(16'hF000, 4'b0001, 1'b0);
    applyStimulus(16'hF001, 4'b0001, 1'b0);
    applyStimulus(16'hF002, 4'b0001, 1'b0);
    checkOutput("t1_valid_pre", 32'(bus.valid_out), 32'h1);
    checkOutput("t1_head_pre",  32'(bus.data_out),  32'hF000);
    checkOutput("t1_state_pre", 32'(bus.state),     32'h1);
    @(negedge clk);
    bus.data_in    = 16'hF003;
    bus.control_in = 4'b0001;
    #2 reset = 1'b1;
    #1;
    checkOutput("t1_valid_async", 32'(bus.valid_out), 32'h0);
    checkOutput("t1_data_async",  32'(bus.data_out),  32'h0);
    checkOutput("t1_state_async", 32'(bus.state),     32'h0);
    @(posedge clk);
    #1;
    checkOutput("t1_no_push", 32'(bus.valid_out), 32'h0);
    checkOutput("t1_err",     32'(bus.err_count), 32'h0);
    @(negedge clk);
    bus.control_in = 4'b0000;
    reset          = 1'b0;

    // T2: resync after a bad header, then a sequence error with the FIFO full
    applyStimulus(16'hFBA0, 4'b0001, 1'b0);
    applyStimulus(16'hF0A1, 4'b0001, 1'b0);
    applyStimulus(16'hF102, 4'b0001, 1'b0);
    checkOutput("t2_err0", 32'(bus.err_count), 32'h0);
    applyStimulus(16'hA5D3, 4'b0001, 1'b0);
    checkOutput("t2_err1",   32'(bus.err_count), 32'h1);
    checkOutput("t2_state2", 32'(bus.state),     32'h2);
    checkOutput("t2_serr1",  32'(bus.seq_error), 32'h1);
    applyStimulus(16'hF1F0, 4'b0001, 1'b0);
    checkOutput("t2_resync", 32'(bus.state),     32'h1);
    checkOutput("t2_full",   32'(bus.full),      32'h1);
    checkOutput("t2_serr0",  32'(bus.seq_error), 32'h0);
    applyStimulus(16'hFDC9, 4'b0001, 1'b0);
    checkOutput("t2_err2",   32'(bus.err_count),  32'h2);
    checkOutput("t2_drop0",  32'(bus.drop_count), 32'h0);
    checkOutput("t2_state3", 32'(bus.state),      32'h2);
    checkOutput("t2_head0",  32'(bus.data_out),   32'hFBA0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t2_head1", 32'(bus.data_out), 32'hF0A1);
    checkOutput("t2_nfull", 32'(bus.full),     32'h0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t2_head2", 32'(bus.data_out), 32'hF102);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t2_head3", 32'(bus.data_out), 32'hF1F0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t2_empty", 32'(bus.valid_out), 32'h0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t2_pop_empty", 32'(bus.valid_out), 32'h0);

    // T3: sequence nibble wraps F->0; F001 must then be accepted
    resetDut();
    applyStimulus(16'hF00E, 4'b0001, 1'b0);
    applyStimulus(16'hF00F, 4'b0001, 1'b0);
    applyStimulus(16'hF000, 4'b0001, 1'b0);
    checkOutput("t3_err_wrap", 32'(bus.err_count), 32'h0);
    applyStimulus(16'hF001, 4'b0001, 1'b0);
    checkOutput("t3_err_next", 32'(bus.err_count), 32'h0);
    checkOutput("t3_full",     32'(bus.full),      32'h1);
    checkOutput("t3_head",     32'(bus.data_out),  32'hF00E);
    checkOutput("t3_state",    32'(bus.state),     32'h1);

    // T4: good word offered while full is dropped
    resetDut();
    applyStimulus(16'hF000, 4'b0001, 1'b0);
    applyStimulus(16'hF001, 4'b0001, 1'b0);
    applyStimulus(16'hF002, 4'b0001, 1'b0);
    applyStimulus(16'hF003, 4'b0001, 1'b0);
    checkOutput("t4_ovf0", 32'(bus.overflow), 32'h0);
    applyStimulus(16'hF0A4, 4'b0001, 1'b0);
    checkOutput("t4_drop", 32'(bus.drop_count), 32'h1);
    checkOutput("t4_ovf1", 32'(bus.overflow),   32'h1);
    checkOutput("t4_err",  32'(bus.err_count),  32'h0);
    checkOutput("t4_head", 32'(bus.data_out),   32'hF000);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t4_head_next", 32'(bus.data_out), 32'hF001);
    checkOutput("t4_nfull",     32'(bus.full),     32'h0);
    checkOutput("t4_ovf_stick", 32'(bus.overflow), 32'h1);
    // expected advanced past the dropped word, so F005 is in sequence
    applyStimulus(16'hF005, 4'b0001, 1'b0);
    checkOutput("t4_seq_after_drop", 32'(bus.err_count), 32'h0);
    checkOutput("t4_full_again",     32'(bus.full),      32'h1);

    // T5: push and pop in the same cycle keep occupancy
    resetDut();
    applyStimulus(16'hF000, 4'b0001, 1'b0);
    applyStimulus(16'hF001, 4'b0001, 1'b0);
    applyStimulus(16'hF0A2, 4'b0001, 1'b1);
    checkOutput("t5_head",  32'(bus.data_out),  32'hF001);
    checkOutput("t5_valid", 32'(bus.valid_out), 32'h1);
    checkOutput("t5_full",  32'(bus.full),      32'h0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t5_head2", 32'(bus.data_out),  32'hF0A2);
    checkOutput("t5_valid2", 32'(bus.valid_out), 32'h1);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t5_empty", 32'(bus.valid_out), 32'h0);

    // T6: upstream error flag rejects an otherwise good word
    resetDut();
    applyStimulus(16'hF000, 4'b0001, 1'b0);
    applyStimulus(16'hF0A1, 4'b0010, 1'b0);
    checkOutput("t6_no_offer", 32'(bus.err_count), 32'h0);
    applyStimulus(16'hF0A1, 4'b0011, 1'b0);
    checkOutput("t6_serr", 32'(bus.seq_error), 32'h1);
    checkOutput("t6_err",  32'(bus.err_count), 32'h1);
    checkOutput("t6_state", 32'(bus.state),    32'h2);
    checkOutput("t6_head", 32'(bus.data_out),  32'hF000);
    applyStimulus(16'h0000, 4'b0000, 1'b0);
    checkOutput("t6_serr_pulse", 32'(bus.seq_error), 32'h0);
    applyStimulus(16'h0000, 4'b0000, 1'b1);
    checkOutput("t6_one_word", 32'(bus.valid_out), 32'h0);

    // err_count saturates at 255
    for (int i = 0; i < 260; i++) applyStimulus(16'h0000, 4'b0001, 1'b0);
    checkOutput("sat_err", 32'(bus.err_count), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
